// File: rtl/spi_arb_pkg.sv
// Shared types and constants for the SPI master arbiter.
package spi_arb_pkg;

  localparam int unsigned ByteW          = 8;
  localparam int unsigned DefaultTimeout = 1024;

  typedef enum logic [2:0] {
    StIdle,
    StLoad,
    StStart,
    StWaitCsLow,
    StWaitCsHigh,
    StDone
  } spi_arb_state_e;

endpackage

// File: rtl/spi_rr_arbiter.sv
// Combinational round-robin picker: first asserted valid at or above ptr_i, with wrap-around.
module spi_rr_arbiter #(
  parameter  int unsigned NumReq = 4,
  localparam int unsigned IdxW   = $clog2(NumReq)
) (
  input  logic [NumReq-1:0] valid_i,
  input  logic [IdxW-1:0]   ptr_i,
  output logic              found_o,
  output logic [IdxW-1:0]   idx_o
);

  logic [IdxW-1:0] cand;
  logic            hit;

  // Scan NumReq candidates starting at the pointer; the first hit wins.
  always_comb begin
    hit  = 1'b0;
    cand = '0;
    idx_o = '0;
    for (int unsigned i = 0; i < NumReq; i++) begin
      cand = IdxW'((32'(ptr_i) + i) % NumReq);
      if (!hit && valid_i[cand]) begin
        hit   = 1'b1;
        idx_o = cand;
      end
    end
    found_o = hit;
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin front end sharing one SPI master between NUM_REQ byte requesters.
// Optional feature: define SPI_ARB_TIMEOUT_EN to add a per-phase watchdog on the
// chip-select wait states that reports req_err_o instead of req_done_o.
module spi_master_arbiter
  import spi_arb_pkg::*;
#(
  parameter  int unsigned NUM_REQ        = 4,
  parameter  int unsigned TIMEOUT_CYCLES = DefaultTimeout,
  localparam int unsigned IdxW           = $clog2(NUM_REQ)
) (
  input  logic                     clk_i,
  input  logic                     aresetn_i,
  input  logic [NUM_REQ-1:0]       req_valid_i,
  input  logic [NUM_REQ*ByteW-1:0] req_data_i,
  output logic [NUM_REQ-1:0]       req_ready_o,
  output logic [NUM_REQ-1:0]       req_done_o,
  output logic [NUM_REQ-1:0]       req_err_o,
  output logic                     spi_load_o,
  output logic                     spi_start_o,
  output logic [ByteW-1:0]         spi_data_o,
  input  logic                     spi_cs_i,
  output logic                     busy_o,
  output logic [IdxW-1:0]          grant_idx_o
);

  if (NUM_REQ < 2 || NUM_REQ > 8) begin : g_bad_num_req
    $error("NUM_REQ must be within 2..8");
  end
  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  spi_arb_state_e  state_q, state_d;
  logic [ByteW-1:0] data_q, data_d;
  logic [IdxW-1:0] gidx_q, gidx_d;
  logic [IdxW-1:0] rr_q, rr_d;
  logic            arb_found;
  logic [IdxW-1:0] arb_idx;
  logic [IdxW-1:0] rr_next;
  logic            timed_out;
  logic [NUM_REQ-1:0] ready_c;

  logic [ByteW-1:0] req_bytes [NUM_REQ];
  for (genvar k = 0; k < NUM_REQ; k++) begin : g_bytes
    assign req_bytes[k] = req_data_i[k*ByteW +: ByteW];
  end

  spi_rr_arbiter #(
    .NumReq (NUM_REQ)
  ) u_rr (
    .valid_i (req_valid_i),
    .ptr_i   (rr_q),
    .found_o (arb_found),
    .idx_o   (arb_idx)
  );

  assign rr_next = (gidx_q == IdxW'(NUM_REQ - 1)) ? '0 : gidx_q + 1'b1;

`ifdef SPI_ARB_TIMEOUT_EN
  logic [31:0] cnt_q, cnt_d;
  logic        err_q, err_d;
  assign timed_out = err_q;
`else
  assign timed_out = 1'b0;
`endif

  // Next-state, datapath capture and one-cycle output pulses.
  always_comb begin
    state_d     = state_q;
    data_d      = data_q;
    gidx_d      = gidx_q;
    rr_d        = rr_q;
    ready_c     = '0;
    req_done_o  = '0;
    req_err_o   = '0;
    spi_load_o  = 1'b0;
    spi_start_o = 1'b0;
    case (state_q)
      StIdle: begin
        if (arb_found) begin
          ready_c = NUM_REQ'(1) << arb_idx;
          data_d  = req_bytes[arb_idx];
          gidx_d  = arb_idx;
          state_d = StLoad;
        end
      end
      StLoad: begin
        spi_load_o = 1'b1;
        state_d    = StStart;
      end
      StStart: begin
        spi_start_o = 1'b1;
        state_d     = StWaitCsLow;
      end
      StWaitCsLow: begin
        if (!spi_cs_i) state_d = StWaitCsHigh;
      end
      StWaitCsHigh: begin
        if (spi_cs_i) state_d = StDone;
      end
      StDone: begin
        if (timed_out) req_err_o  = NUM_REQ'(1) << gidx_q;
        else           req_done_o = NUM_REQ'(1) << gidx_q;
        rr_d    = rr_next;
        state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

`ifdef SPI_ARB_TIMEOUT_EN
    // Counter restarts on every wait-state entry; expiry overrides the cs handshake.
    cnt_d = '0;
    err_d = err_q;
    if (state_q == StWaitCsLow || state_q == StWaitCsHigh) begin
      if (state_d == state_q) cnt_d = cnt_q + 32'd1;
      if (cnt_q == TIMEOUT_CYCLES - 1) begin
        state_d = StDone;
        err_d   = 1'b1;
        cnt_d   = '0;
      end
    end
    if (state_q == StDone) err_d = 1'b0;
`endif
  end

  // Keep the accept pulse quiet while reset is held, even if requesters are valid.
  assign req_ready_o = ready_c & {NUM_REQ{aresetn_i}};
  assign busy_o      = (state_q != StIdle);
  assign spi_data_o  = data_q;
  assign grant_idx_o = gidx_q;

  // State, captured byte, grant index and round-robin pointer.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      state_q <= StIdle;
      data_q  <= '0;
      gidx_q  <= '0;
      rr_q    <= '0;
    end else begin
      state_q <= state_d;
      data_q  <= data_d;
      gidx_q  <= gidx_d;
      rr_q    <= rr_d;
    end
  end

`ifdef SPI_ARB_TIMEOUT_EN
  // Watchdog counter and timeout flag.
  always_ff @(posedge clk_i or negedge aresetn_i) begin
    if (!aresetn_i) begin
      cnt_q <= '0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end
`endif

endmodule

// File: doc/spi_master_arbiter.md
# spi_master_arbiter

Round-robin controller that shares one SPI master between N byte-level requesters. It accepts one byte per grant and drives the master's load/start/data inputs in sequence. It tracks the master's chip-select to detect when the transfer completes, then reports completion to the granted requester. It sits directly in front of the SPI master in the same clock domain.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- TIMEOUT_CYCLES, 1024, per-phase watchdog limit in clk_i cycles (used only when the timeout feature is compiled in)

- clk_i  in  1  system clock, all logic on rising edge
- aresetn_i  in  1  reset, asynchronous and active-low
- req_valid_i  in  NUM_REQ  per-requester byte available
- req_data_i  in  NUM_REQ*8  per-requester byte; requester k uses bits [8k+7:8k]
- req_ready_o  out  NUM_REQ  one-hot, one-cycle pulse: byte accepted
- req_done_o  out  NUM_REQ  one-hot, one-cycle pulse: transfer finished
- req_err_o  out  NUM_REQ  one-hot, one-cycle pulse: transfer aborted by timeout (tied 0 without the macro)
- spi_load_o  out  1  to master load_i
- spi_start_o  out  1  to master start_i
- spi_data_o  out  8  to master data_i
- spi_cs_i  in  1  from master cs_o; active-low, 1 = idle
- busy_o  out  1  high in every state except IDLE
- grant_idx_o  out  $clog2(NUM_REQ)  index of the current or last granted requester

## Operation
- FSM states: IDLE, LOAD, START, WAIT_CS_LOW, WAIT_CS_HIGH, DONE.
- IDLE:
  - Select the first asserted req_valid_i, searching from rr_ptr upward with wrap-around.
  - If one is found: pulse req_ready_o[g], capture its byte into spi_data_o, set grant_idx_o=g, go to LOAD.
- LOAD: spi_load_o=1 for exactly one cycle, then START.
- START: spi_start_o=1 for exactly one cycle, then WAIT_CS_LOW.
- WAIT_CS_LOW: stay until spi_cs_i==0, then WAIT_CS_HIGH.
- WAIT_CS_HIGH: stay until spi_cs_i==1, then DONE.
- DONE:
  - Pulse req_done_o[grant_idx_o].
  - Set rr_ptr = grant_idx_o+1, wrapping to 0 at NUM_REQ.
  - Go to IDLE.
- spi_data_o holds the captured byte until the next grant.
- A requester deasserting valid before it is granted is simply skipped; no grant is issued and nothing is lost.
- req_data_i is sampled only in the grant cycle; later changes have no effect.
- All requests are ignored while busy_o=1. No queueing inside the block.

## Timing
- Reset values:
  - All outputs 0, except grant_idx_o=0.
  - spi_data_o=8'h00, rr_ptr=0, state IDLE.
- Reset asserted mid-transfer: immediate return to reset values, with no done or err pulse. The master is reset by the same aresetn_i.
- Grant cycle T (IDLE with a valid request): req_ready_o pulses at T.
- spi_load_o is high at T+1 and spi_start_o is high at T+2.
- With spi_cs_i falling at cycle A and rising at cycle B:
  - WAIT_CS_HIGH is entered at A+1.
  - DONE is at B+1, and req_done_o pulses at B+1.
  - The earliest next grant is at B+2.
- Simultaneous valid requests: exactly one grant per IDLE cycle, by round-robin priority.
- spi_cs_i already 0 on entry to WAIT_CS_LOW: leave WAIT_CS_LOW on the next edge.

## Configuration
- SPI_ARB_TIMEOUT_EN defined:
  - A counter runs in WAIT_CS_LOW and WAIT_CS_HIGH and is cleared on each state entry.
  - When it reaches TIMEOUT_CYCLES-1, pulse req_err_o[grant_idx_o] instead of req_done_o.
  - rr_ptr then advances as in DONE and the FSM returns to IDLE.
- SPI_ARB_TIMEOUT_EN undefined: no counter; req_err_o is tied 0; the WAIT states can wait indefinitely.

## Structure
- Package spi_arb_pkg holds:
  - the state enum type
  - the byte width constant (8)
  - the default timeout constant
- Sub-module spi_rr_arbiter is combinational: it takes (valid vector, rr_ptr) and returns (found, index).
  - Pointer and FSM registers stay in spi_master_arbiter.

## Test plan
- Single request: req_valid_i[2]=1 with byte 0xA5 -> req_ready_o[2] at T, spi_load_o at T+1 with spi_data_o=0xA5, spi_start_o at T+2; cs pulse low for 16 cycles -> req_done_o[2] one cycle after cs rises.
- All 4 valid continuously, NUM_REQ=4 -> grants in order 0,1,2,3,0; no requester is granted twice before every other valid one is granted.
- Valid withdrawn: req 1 is valid only while busy and drops before IDLE -> no grant to req 1; next grant goes to the next valid index.
- Reset during WAIT_CS_HIGH -> all outputs return to 0 immediately; no done pulse; the first grant after reset uses rr_ptr=0.
- SPI_ARB_TIMEOUT_EN with TIMEOUT_CYCLES=8 and spi_cs_i held at 1 -> req_err_o[g] pulses 8 cycles after WAIT_CS_LOW entry and busy_o drops.
- Back-to-back traffic: req 0 always valid, cs toggles -> next req_ready_o[0] exactly one cycle after req_done_o[0].
